// File: rtl/vid_timing_pkg.sv
// Shared types and timing tables for the pixel-domain display timing generator.
package vid_timing_pkg;

    localparam int unsigned VT_W = 16;

    typedef enum logic [1:0] {
        VID_640X480   = 2'd0,
        VID_1920X1080 = 2'd1,
        VID_1280X720  = 2'd2,
        VID_CUSTOM    = 2'd3
    } vid_mode_e;

    typedef struct packed {
        logic [VT_W-1:0] hact;
        logic [VT_W-1:0] hfp;
        logic [VT_W-1:0] hsw;
        logic [VT_W-1:0] hbp;
        logic [VT_W-1:0] vact;
        logic [VT_W-1:0] vfp;
        logic [VT_W-1:0] vsw;
        logic [VT_W-1:0] vbp;
        logic            hpol;
        logic            vpol;
    } vid_timing_t;

    localparam vid_timing_t VID_T_640X480 = '{
        hact: VT_W'(640),  hfp: VT_W'(16), hsw: VT_W'(96), hbp: VT_W'(48),
        vact: VT_W'(480),  vfp: VT_W'(10), vsw: VT_W'(2),  vbp: VT_W'(33),
        hpol: 1'b0, vpol: 1'b0
    };

    localparam vid_timing_t VID_T_1920X1080 = '{
        hact: VT_W'(1920), hfp: VT_W'(88), hsw: VT_W'(44), hbp: VT_W'(148),
        vact: VT_W'(1080), vfp: VT_W'(4),  vsw: VT_W'(5),  vbp: VT_W'(36),
        hpol: 1'b1, vpol: 1'b1
    };

    localparam vid_timing_t VID_T_1280X720 = '{
        hact: VT_W'(1280), hfp: VT_W'(110), hsw: VT_W'(40), hbp: VT_W'(220),
        vact: VT_W'(720),  vfp: VT_W'(5),   vsw: VT_W'(5),  vbp: VT_W'(20),
        hpol: 1'b1, vpol: 1'b1
    };

    // Timing for a mode; the custom entry is supplied by the instantiating block.
    function automatic vid_timing_t vid_timing(input vid_mode_e mode, input vid_timing_t custom);
        vid_timing_t t;
        case (mode)
            VID_640X480:   t = VID_T_640X480;
            VID_1920X1080: t = VID_T_1920X1080;
            VID_1280X720:  t = VID_T_1280X720;
            default:       t = custom;
        endcase
        return t;
    endfunction

    // Idle sync levels {hsync, vsync} for a mode (the inverse of its polarity).
    function automatic logic [1:0] vid_idle_sync(input vid_mode_e mode, input logic [1:0] custom_pol);
        logic [1:0] pol;
        case (mode)
            VID_640X480:   pol = {VID_T_640X480.hpol,   VID_T_640X480.vpol};
            VID_1920X1080: pol = {VID_T_1920X1080.hpol, VID_T_1920X1080.vpol};
            VID_1280X720:  pol = {VID_T_1280X720.hpol,  VID_T_1280X720.vpol};
            default:       pol = custom_pol;
        endcase
        return ~pol;
    endfunction

    function automatic int unsigned vid_h_total(input vid_timing_t t);
        return 32'(t.hact) + 32'(t.hfp) + 32'(t.hsw) + 32'(t.hbp);
    endfunction

    function automatic int unsigned vid_v_total(input vid_timing_t t);
        return 32'(t.vact) + 32'(t.vfp) + 32'(t.vsw) + 32'(t.vbp);
    endfunction

endpackage

// File: rtl/vid_delay_line.sv
// Fixed-depth register pipe; every stage loads a run-time reset value while rst is high.
module vid_delay_line #(
    parameter int unsigned W     = 1,
    parameter int unsigned DELAY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DELAY == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst, rst_val};
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] stage_q [DELAY];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(DELAY); i++) stage_q[i] <= rst_val;
            end else begin
                stage_q[0] <= d;
                for (int i = 1; i < int'(DELAY); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q = stage_q[DELAY-1];
    end

endmodule

// File: rtl/vid_timing_gen.sv
// Runtime-switchable display timing generator: counters, sync/DE decode and
// an aligned output delay; mode changes take effect on the frame wrap.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int unsigned CW     = 12,
    parameter int unsigned DELAY  = 1,
    parameter int unsigned C_HACT = 800,
    parameter int unsigned C_HFP  = 40,
    parameter int unsigned C_HSW  = 128,
    parameter int unsigned C_HBP  = 88,
    parameter int unsigned C_VACT = 600,
    parameter int unsigned C_VFP  = 1,
    parameter int unsigned C_VSW  = 4,
    parameter int unsigned C_VBP  = 23,
    parameter bit          C_HPOL = 1'b1,
    parameter bit          C_VPOL = 1'b1
) (
    input  logic          clk_pix,
    input  logic          rst_pix,
    input  logic [1:0]    mode_req,
    output logic [1:0]    mode_cur,
    output logic          mode_pend,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start,
    output logic          line_start
);

    localparam int unsigned PW = 2 * CW + 5;

    localparam vid_timing_t CUSTOM = '{
        hact: VT_W'(C_HACT), hfp: VT_W'(C_HFP), hsw: VT_W'(C_HSW), hbp: VT_W'(C_HBP),
        vact: VT_W'(C_VACT), vfp: VT_W'(C_VFP), vsw: VT_W'(C_VSW), vbp: VT_W'(C_VBP),
        hpol: C_HPOL, vpol: C_VPOL
    };

    // Elaboration-time sanity checks on parameters and mode totals.
    if (DELAY > 4) begin : g_bad_delay
        $error("vid_timing_gen: DELAY must be 0..4");
    end

    if (C_HACT == 0 || C_HFP == 0 || C_HSW == 0 || C_HBP == 0 ||
        C_VACT == 0 || C_VFP == 0 || C_VSW == 0 || C_VBP == 0) begin : g_bad_custom
        $error("vid_timing_gen: custom timing values must all be nonzero");
    end

    for (genvar gm = 0; gm < 4; gm++) begin : g_mode_chk
        localparam vid_timing_t T = vid_timing(vid_mode_e'(2'(gm)), CUSTOM);
        if (64'(vid_h_total(T)) > (64'd1 << CW) ||
            64'(vid_v_total(T)) > (64'd1 << CW)) begin : g_bad_total
            $error("vid_timing_gen: mode totals do not fit in CW bits");
        end
    end

    vid_mode_e     cur_q;
    vid_timing_t   cur_t;
    logic [CW-1:0] sx_q, sy_q;
    logic [CW-1:0] h_act, h_ss, h_se, h_last;
    logic [CW-1:0] v_act, v_ss, v_se, v_last;
    logic          line_end, frame_end;
    logic          hs_act, vs_act;
    logic [1:0]    req_idle;
    logic [PW-1:0] live_w, rst_w, pre_w, out_w;

    assign cur_t = vid_timing(cur_q, CUSTOM);

    // Region boundaries of the active mode, all at CW bits.
    assign h_act  = CW'(cur_t.hact);
    assign h_ss   = h_act + CW'(cur_t.hfp);
    assign h_se   = h_ss + CW'(cur_t.hsw);
    assign h_last = h_se + CW'(cur_t.hbp) - CW'(1);
    assign v_act  = CW'(cur_t.vact);
    assign v_ss   = v_act + CW'(cur_t.vfp);
    assign v_se   = v_ss + CW'(cur_t.vsw);
    assign v_last = v_se + CW'(cur_t.vbp) - CW'(1);

    assign line_end  = (sx_q == h_last);
    assign frame_end = line_end && (sy_q == v_last);

    // Raster counters; the mode register only moves on the frame wrap.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sx_q  <= '0;
            sy_q  <= '0;
            cur_q <= vid_mode_e'(mode_req);
        end else begin
            if (line_end) begin
                sx_q <= '0;
                sy_q <= frame_end ? '0 : sy_q + CW'(1);
            end else begin
                sx_q <= sx_q + CW'(1);
            end
            if (frame_end) cur_q <= vid_mode_e'(mode_req);
        end
    end

    assign hs_act = (sx_q >= h_ss) && (sx_q < h_se);
    assign vs_act = (sy_q >= v_ss) && (sy_q < v_se);

    // Sync level is resolved before the delay so polarity travels with its sample.
    assign live_w = {sx_q, sy_q,
                     ~(hs_act ^ cur_t.hpol),
                     ~(vs_act ^ cur_t.vpol),
                     (sx_q < h_act) && (sy_q < v_act),
                     (sx_q == '0) && (sy_q == '0),
                     (sx_q == '0)};

    assign req_idle = vid_idle_sync(vid_mode_e'(mode_req), {C_HPOL, C_VPOL});
    assign rst_w    = {CW'(0), CW'(0), req_idle, 3'b000};
    assign pre_w    = rst_pix ? rst_w : live_w;

    vid_delay_line #(
        .W     (PW),
        .DELAY (DELAY)
    ) u_align (
        .clk     (clk_pix),
        .rst     (rst_pix),
        .rst_val (rst_w),
        .d       (pre_w),
        .q       (out_w)
    );

    assign {sx, sy, hsync, vsync, de, frame_start, line_start} = out_w;

    assign mode_cur  = cur_q;
    assign mode_pend = (mode_req != cur_q);

endmodule

// File: tb/tb_vid_timing_gen.sv
// Randomised scoreboard bench for vid_timing_gen: three instances (small custom
// timing at DELAY 0 and 3, default custom timing at default DELAY) vs a raster model.
module tb_vid_timing_gen;

    localparam int unsigned CW = 12;
    localparam int DLY [3] = '{0, 3, 1};

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          hs;
        logic          vs;
        logic          de;
        logic          fs;
        logic          ls;
    } ow_t;

    typedef struct {
        int ha; int hf; int hw; int hb;
        int va; int vf; int vw; int vb;
        bit hp; bit vp;
    } tm_t;

    logic          clk_pix  = 1'b0;
    logic          rst_pix  = 1'b1;
    logic [1:0]    mode_req = 2'd3;
    logic [1:0]    mode_cur_o  [3];
    logic          mode_pend_o [3];
    logic [CW-1:0] sx_o [3];
    logic [CW-1:0] sy_o [3];
    logic          hsync_o [3];
    logic          vsync_o [3];
    logic          de_o [3];
    logic          fs_o [3];
    logic          ls_o [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stop    = 1'b0;
    bit   armed   = 1'b0;
    int   cyc     = 0;
    int   m [3];
    int   p [3];
    ow_t  hist [3][4];
    int   ls_last [3];
    int   ls_per  [3];
    int   fs_last [3];
    int   fs_per  [3];

    always #5 clk_pix = ~clk_pix;

    vid_timing_gen #(
        .CW(CW), .DELAY(0),
        .C_HACT(20), .C_HFP(3), .C_HSW(4), .C_HBP(5),
        .C_VACT(6),  .C_VFP(1), .C_VSW(2), .C_VBP(2),
        .C_HPOL(1'b0), .C_VPOL(1'b1)
    ) u_dut_a0 (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .mode_req(mode_req),
        .mode_cur(mode_cur_o[0]), .mode_pend(mode_pend_o[0]),
        .sx(sx_o[0]), .sy(sy_o[0]), .hsync(hsync_o[0]), .vsync(vsync_o[0]),
        .de(de_o[0]), .frame_start(fs_o[0]), .line_start(ls_o[0])
    );

    vid_timing_gen #(
        .CW(CW), .DELAY(3),
        .C_HACT(20), .C_HFP(3), .C_HSW(4), .C_HBP(5),
        .C_VACT(6),  .C_VFP(1), .C_VSW(2), .C_VBP(2),
        .C_HPOL(1'b0), .C_VPOL(1'b1)
    ) u_dut_a3 (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .mode_req(mode_req),
        .mode_cur(mode_cur_o[1]), .mode_pend(mode_pend_o[1]),
        .sx(sx_o[1]), .sy(sy_o[1]), .hsync(hsync_o[1]), .vsync(vsync_o[1]),
        .de(de_o[1]), .frame_start(fs_o[1]), .line_start(ls_o[1])
    );

    vid_timing_gen u_dut_b (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .mode_req(mode_req),
        .mode_cur(mode_cur_o[2]), .mode_pend(mode_pend_o[2]),
        .sx(sx_o[2]), .sy(sy_o[2]), .hsync(hsync_o[2]), .vsync(vsync_o[2]),
        .de(de_o[2]), .frame_start(fs_o[2]), .line_start(ls_o[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            if (n_fail >= 40) stop = 1'b1;
        end
    endtask

    function automatic tm_t tm_of(int id, int mode);
        tm_t t;
        case (mode)
            0: t = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
            1: t = '{1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1};
            2: t = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
            default: begin
                if (id == 2) t = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
                else         t = '{20, 3, 4, 5, 6, 1, 2, 2, 1'b0, 1'b1};
            end
        endcase
        return t;
    endfunction

    // Expected undelayed outputs for a linear pixel index within the frame.
    function automatic ow_t exp_word(int id, int mode, int pix, bit rst, int req);
        tm_t t;
        ow_t w;
        int  x, y, htot;
        w = '0;
        if (rst) begin
            t = tm_of(id, req);
            w.hs = !t.hp;
            w.vs = !t.vp;
            return w;
        end
        t    = tm_of(id, mode);
        htot = t.ha + t.hf + t.hw + t.hb;
        x    = pix % htot;
        y    = pix / htot;
        w.x  = CW'(x);
        w.y  = CW'(y);
        w.hs = (x >= t.ha + t.hf && x < t.ha + t.hf + t.hw) ? t.hp : !t.hp;
        w.vs = (y >= t.va + t.vf && y < t.va + t.vf + t.vw) ? t.vp : !t.vp;
        w.de = (x < t.ha) && (y < t.va);
        w.fs = (pix == 0);
        w.ls = (x == 0);
        return w;
    endfunction

    function automatic int frame_len(int id, int mode);
        tm_t t;
        t = tm_of(id, mode);
        return (t.ha + t.hf + t.hw + t.hb) * (t.va + t.vf + t.vw + t.vb);
    endfunction

    // One pixel clock: drive, compare every instance, then advance the model over the edge.
    task automatic cycle(input bit r, input logic [1:0] q);
        ow_t w;
        ow_t e;
        @(negedge clk_pix);
        rst_pix  = r;
        mode_req = q;
        #1;
        for (int id = 0; id < 3; id++) begin
            w = exp_word(id, m[id], p[id], r, int'(q));
            if (armed && !stop) begin
                e = (DLY[id] == 0) ? w : hist[id][DLY[id]-1];
                chk($sformatf("d%0d_out@%0d", id, cyc),
                    64'({sx_o[id], sy_o[id], hsync_o[id], vsync_o[id], de_o[id], fs_o[id], ls_o[id]}),
                    64'(e));
                chk($sformatf("d%0d_mode_cur@%0d", id, cyc), 64'(mode_cur_o[id]), 64'(m[id]));
                chk($sformatf("d%0d_mode_pend@%0d", id, cyc), 64'(mode_pend_o[id]),
                    64'(int'(q) != m[id]));
            end
            if (r) begin
                ls_last[id] = -1;
                fs_last[id] = -1;
            end else begin
                if (ls_o[id]) begin
                    if (ls_last[id] >= 0) ls_per[id] = cyc - ls_last[id];
                    ls_last[id] = cyc;
                end
                if (fs_o[id]) begin
                    if (fs_last[id] >= 0) fs_per[id] = cyc - fs_last[id];
                    fs_last[id] = cyc;
                end
            end
            if (r) begin
                for (int k = 0; k < 4; k++) hist[id][k] = w;
                m[id] = int'(q);
                p[id] = 0;
            end else begin
                for (int k = 3; k > 0; k--) hist[id][k] = hist[id][k-1];
                hist[id][0] = w;
                if (p[id] == frame_len(id, m[id]) - 1) begin
                    p[id] = 0;
                    m[id] = int'(q);
                end else begin
                    p[id]++;
                end
            end
        end
        if (r) armed = 1'b1;
        cyc++;
    endtask

    task automatic run(input int n, input bit r, input logic [1:0] q);
        for (int i = 0; i < n; i++) cycle(r, q);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rst_left;
        logic [1:0]  req;
        for (int id = 0; id < 3; id++) begin
            m[id] = 3; p[id] = 0;
            ls_last[id] = -1; ls_per[id] = -1;
            fs_last[id] = -1; fs_per[id] = -1;
        end

        // Custom timing from reset.
        run(4, 1'b1, 2'd3);
        run(1200, 1'b0, 2'd3);
        chk("ls_period_custom_small", 64'(ls_per[0]), 64'd32);
        chk("fs_period_custom_small", 64'(fs_per[0]), 64'd352);
        chk("ls_period_custom_default", 64'(ls_per[2]), 64'd1056);

        // Mid-frame request for 720p applies only at the custom frame wrap.
        run(3700, 1'b0, 2'd2);
        chk("mode_cur_after_wrap", 64'(mode_cur_o[0]), 64'd2);
        chk("mode_pend_after_wrap", 64'(mode_pend_o[0]), 64'd0);
        chk("ls_period_720p", 64'(ls_per[0]), 64'd1650);
        chk("ls_period_720p_d3", 64'(ls_per[1]), 64'd1650);
        chk("mode_cur_unwrapped", 64'(mode_cur_o[2]), 64'd3);
        chk("mode_pend_unwrapped", 64'(mode_pend_o[2]), 64'd1);

        // 1080p lines.
        run(3, 1'b1, 2'd1);
        run(4500, 1'b0, 2'd1);
        chk("ls_period_1080p", 64'(ls_per[0]), 64'd2200);
        chk("ls_period_1080p_b", 64'(ls_per[2]), 64'd2200);

        // 480p, then reset mid-line at (300, 1) requesting 1080p.
        run(3, 1'b1, 2'd0);
        run(1100, 1'b0, 2'd0);
        chk("ls_period_480p", 64'(ls_per[0]), 64'd800);
        run(3, 1'b1, 2'd1);
        chk("rst_hold_out_d0", 64'({sx_o[0], sy_o[0], hsync_o[0], vsync_o[0], de_o[0], fs_o[0], ls_o[0]}), 64'd0);
        chk("rst_hold_out_d3", 64'({sx_o[1], sy_o[1], hsync_o[1], vsync_o[1], de_o[1], fs_o[1], ls_o[1]}), 64'd0);
        chk("rst_mode_cur", 64'(mode_cur_o[1]), 64'd1);
        cycle(1'b0, 2'd1);
        chk("release_fs_d0", 64'(fs_o[0]), 64'd1);
        chk("release_fs_d3_early", 64'(fs_o[1]), 64'd0);
        cycle(1'b0, 2'd1);
        chk("release_fs_d1", 64'(fs_o[2]), 64'd1);
        cycle(1'b0, 2'd1);
        cycle(1'b0, 2'd1);
        chk("release_fs_d3", 64'(fs_o[1]), 64'd1);

        // Random mode requests and reset bursts, biased toward the wrapping custom mode.
        rst_left = 0;
        req      = 2'd3;
        for (int i = 0; i < 40000; i++) begin
            if (rst_left == 0 && $urandom_range(1999, 0) == 0) rst_left = int'($urandom_range(3, 1));
            if ($urandom_range(299, 0) == 0)
                req = ($urandom_range(1, 0) == 1) ? 2'd3 : 2'($urandom_range(3, 0));
            cycle(rst_left != 0, req);
            if (rst_left != 0) rst_left--;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
